// File: rtl/axi_wr_burst_master.sv
// AXI4 INCR write master: drains req_len FIFO beats as bursts of at most MAX_BURST beats (4 KB split when AXI_4K_SPLIT_EN is defined).
// First awvalid 3 cycles after the request edge; W beats follow fifo_empty/wready directly; done the cycle after the last B.
module axi_wr_burst_master #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 64,
   parameter int LSIZE     = 9,
   parameter int MAX_BURST = 256
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic                  frame_sync,
   input  logic                  burst_req,
   input  logic                  tail_req,
   input  logic [LSIZE-1:0]      req_len,
   output logic                  resp,
   output logic                  done,
   input  logic [DATA_W-1:0]     fifo_dout,
   input  logic                  fifo_empty,
   output logic                  fifo_rd,
   output logic [ADDR_W-1:0]     awaddr,
   output logic [7:0]            awlen,
   output logic [2:0]            awsize,
   output logic [1:0]            awburst,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [DATA_W-1:0]     wdata,
   output logic [DATA_W/8-1:0]   wstrb,
   output logic                  wlast,
   output logic                  wvalid,
   input  logic                  wready,
   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready,
   output logic                  err
);

   localparam int BYTES  = DATA_W / 8;
   localparam int SIZE_L = $clog2(BYTES);
   localparam int BW     = $clog2(MAX_BURST + 1);

   typedef enum logic [2:0] {IDLE, ACK, CALC, AW, W, B, FIN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] cur_addr;
   logic [LSIZE-1:0]  remain;
   logic [BW-1:0]     beats;
   logic [BW-1:0]     beat_cnt;
   logic              sync_pend;
   logic [BW-1:0]     calc_beats;
   logic              last_beat;

   // Burst size for the next sub-burst, evaluated from the registered remain/cur_addr.
   always_comb begin
      logic [31:0] lim;
      lim = 32'(MAX_BURST);
`ifdef AXI_4K_SPLIT_EN
      begin
         logic [31:0] to_4k;
         to_4k = (32'd4096 - 32'(cur_addr[11:0])) >> SIZE_L;
         if (to_4k < lim)
            lim = to_4k;
      end
`endif
      if (32'(remain) < lim)
         lim = 32'(remain);
      calc_beats = BW'(lim);
   end

   assign last_beat = (beat_cnt == beats - BW'(1));
   assign wvalid    = (state == W) && !fifo_empty;
   assign wdata     = fifo_dout;
   assign wlast     = wvalid && last_beat;
   assign fifo_rd   = wvalid && wready;
   assign awsize    = 3'(SIZE_L);
   assign awburst   = 2'b01;
   assign wstrb     = '1;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cur_addr  <= '0;
         remain    <= '0;
         beats     <= '0;
         beat_cnt  <= '0;
         sync_pend <= 1'b0;
         resp      <= 1'b0;
         done      <= 1'b0;
         awaddr    <= '0;
         awlen     <= '0;
         awvalid   <= 1'b0;
         bready    <= 1'b0;
         err       <= 1'b0;
      end else begin
         resp <= 1'b0;
         done <= 1'b0;
         if (frame_sync && state != IDLE)
            sync_pend <= 1'b1;
         // Clear first; an error response in the same cycle below overrides it.
         if (frame_sync)
            err <= 1'b0;

         case (state)
            IDLE: begin
               if (frame_sync || sync_pend) begin
                  cur_addr  <= base_addr;
                  sync_pend <= 1'b0;
               end
               if (burst_req || tail_req) begin
                  remain <= req_len;
                  resp   <= 1'b1;
                  state  <= ACK;
               end
            end
            ACK: begin
               if (remain == '0) begin
                  done  <= 1'b1;
                  state <= FIN;
               end else begin
                  state <= CALC;
               end
            end
            CALC: begin
               beats    <= calc_beats;
               awlen    <= 8'(calc_beats - BW'(1));
               awaddr   <= cur_addr;
               awvalid  <= 1'b1;
               beat_cnt <= '0;
               state    <= AW;
            end
            AW: begin
               if (awready) begin
                  awvalid <= 1'b0;
                  state   <= W;
               end
            end
            W: begin
               if (wvalid && wready) begin
                  beat_cnt <= beat_cnt + BW'(1);
                  if (last_beat) begin
                     bready <= 1'b1;
                     state  <= B;
                  end
               end
            end
            B: begin
               if (bvalid) begin
                  bready   <= 1'b0;
                  cur_addr <= cur_addr + (ADDR_W'(beats) << SIZE_L);
                  remain   <= remain - LSIZE'(beats);
                  if (bresp != 2'b00)
                     err <= 1'b1;
                  if (remain == LSIZE'(beats)) begin
                     done  <= 1'b1;
                     state <= FIN;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            FIN: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
